// File: rtl/pipe_ctrl.sv
// Pipeline control unit for the 5-stage RV32I core.
// Generates hold/flush/redirect controls for load-use bubbles, jumps and data-memory waits.
module pipe_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1_addr_i,
   input  logic [4:0]       id_rs2_addr_i,
   input  logic             id_rs1_use_i,
   input  logic             id_rs2_use_i,
   input  logic [4:0]       idex_rd_addr_i,
   input  logic             idex_wb_en_i,
   input  logic             idex_mem_en_i,
   input  logic             ex_jump_en_i,
   input  logic [31:0]      ex_jump_addr_i,
   input  logic             mem_req_i,
   input  logic             mem_ready_i,
   output logic             ctrl_pc_hold_o,
   output logic             ctrl_ifid_hold_o,
   output logic             ctrl_ifid_flush_o,
   output logic             ctrl_idex_hold_o,
   output logic             ctrl_idex_flush_o,
   output logic             ctrl_exmem_hold_o,
   output logic             ctrl_memwb_flush_o,
   output logic             ctrl_pc_jump_en_o,
   output logic [31:0]      ctrl_pc_jump_addr_o,
   output logic             ctrl_bus_err_o,
   output logic [CNT_W-1:0] ctrl_stall_cnt_o
);

   typedef enum logic [1:0] {RUN, MEM_WAIT, ABORT} state_t;

   localparam int WAIT_W = 8;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   state_t            state, next_state;
   logic [WAIT_W-1:0] wait_cnt, wait_next;
   logic              bus_err_set;
   logic              mem_stall;
   logic              load_use;
   logic              run_eval;

   assign mem_stall = mem_req_i & ~mem_ready_i;
   assign load_use  = idex_mem_en_i & idex_wb_en_i & (idex_rd_addr_i != 5'd0) &
                      ((id_rs1_use_i & (id_rs1_addr_i == idex_rd_addr_i)) |
                       (id_rs2_use_i & (id_rs2_addr_i == idex_rd_addr_i)));

   // Next state and all pipeline controls; reset forces every control to zero.
   always_comb begin
      ctrl_pc_hold_o      = 1'b0;
      ctrl_ifid_hold_o    = 1'b0;
      ctrl_ifid_flush_o   = 1'b0;
      ctrl_idex_hold_o    = 1'b0;
      ctrl_idex_flush_o   = 1'b0;
      ctrl_exmem_hold_o   = 1'b0;
      ctrl_memwb_flush_o  = 1'b0;
      ctrl_pc_jump_en_o   = 1'b0;
      ctrl_pc_jump_addr_o = 32'd0;
      next_state          = state;
      wait_next           = wait_cnt;
      bus_err_set         = 1'b0;
      run_eval            = 1'b0;
      if (!rst) begin
         case (state)
            RUN: begin
               if (mem_stall) begin
                  ctrl_pc_hold_o     = 1'b1;
                  ctrl_ifid_hold_o   = 1'b1;
                  ctrl_idex_hold_o   = 1'b1;
                  ctrl_exmem_hold_o  = 1'b1;
                  ctrl_memwb_flush_o = 1'b1;
                  next_state         = MEM_WAIT;
                  wait_next          = WAIT_W'(1);
               end else begin
                  run_eval = 1'b1;
               end
            end
            MEM_WAIT: begin
               if (mem_ready_i) begin
                  next_state = RUN;
                  wait_next  = '0;
                  run_eval   = 1'b1;
               end else begin
                  ctrl_pc_hold_o     = 1'b1;
                  ctrl_ifid_hold_o   = 1'b1;
                  ctrl_idex_hold_o   = 1'b1;
                  ctrl_exmem_hold_o  = 1'b1;
                  ctrl_memwb_flush_o = 1'b1;
                  if (wait_cnt == WAIT_LAST) begin
                     next_state  = ABORT;
                     wait_next   = '0;
                     bus_err_set = 1'b1;
                  end else begin
                     wait_next = wait_cnt + WAIT_W'(1);
                  end
               end
            end
            ABORT: begin
               ctrl_memwb_flush_o = 1'b1;
               next_state         = RUN;
            end
            default: next_state = RUN;
         endcase
         // A taken jump flushes the dependent ID instruction, so it outranks load-use.
         if (run_eval) begin
            if (ex_jump_en_i) begin
               ctrl_pc_jump_en_o   = 1'b1;
               ctrl_pc_jump_addr_o = ex_jump_addr_i;
               ctrl_ifid_flush_o   = 1'b1;
               ctrl_idex_flush_o   = 1'b1;
            end else if (load_use) begin
               ctrl_pc_hold_o    = 1'b1;
               ctrl_ifid_hold_o  = 1'b1;
               ctrl_idex_flush_o = 1'b1;
            end
         end
      end
   end

   // State, wait counter, sticky bus error and saturating stall counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= RUN;
         wait_cnt         <= '0;
         ctrl_bus_err_o   <= 1'b0;
         ctrl_stall_cnt_o <= '0;
      end else begin
         state    <= next_state;
         wait_cnt <= wait_next;
         if (bus_err_set) begin
            ctrl_bus_err_o <= 1'b1;
         end
         if (ctrl_pc_hold_o && (ctrl_stall_cnt_o != {CNT_W{1'b1}})) begin
            ctrl_stall_cnt_o <= ctrl_stall_cnt_o + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl: load-use, jump, memory wait, timeout abort and reset.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs1_addr, id_rs2_addr, idex_rd_addr;
   logic        id_rs1_use, id_rs2_use, idex_wb_en, idex_mem_en;
   logic        ex_jump_en;
   logic [31:0] ex_jump_addr;
   logic        mem_req, mem_ready;
   logic        pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush;
   logic        exmem_hold, memwb_flush, pc_jump_en, bus_err;
   logic [31:0] pc_jump_addr, stall_cnt;

   int checks   = 0;
   int failures = 0;

   // Control vector: {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, memwb_flush, jump_en}
   localparam logic [7:0] NONE  = 8'b0000_0000;
   localparam logic [7:0] STALL = 8'b1101_0110;
   localparam logic [7:0] LU    = 8'b1100_1000;
   localparam logic [7:0] JMP   = 8'b0010_1001;
   localparam logic [7:0] ABRT  = 8'b0000_0010;

   logic [7:0] ctrl;
   assign ctrl = {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush,
                  exmem_hold, memwb_flush, pc_jump_en};

   always #5 clk = ~clk;

   pipe_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr),
      .id_rs1_use_i(id_rs1_use), .id_rs2_use_i(id_rs2_use),
      .idex_rd_addr_i(idex_rd_addr), .idex_wb_en_i(idex_wb_en), .idex_mem_en_i(idex_mem_en),
      .ex_jump_en_i(ex_jump_en), .ex_jump_addr_i(ex_jump_addr),
      .mem_req_i(mem_req), .mem_ready_i(mem_ready),
      .ctrl_pc_hold_o(pc_hold), .ctrl_ifid_hold_o(ifid_hold), .ctrl_ifid_flush_o(ifid_flush),
      .ctrl_idex_hold_o(idex_hold), .ctrl_idex_flush_o(idex_flush),
      .ctrl_exmem_hold_o(exmem_hold), .ctrl_memwb_flush_o(memwb_flush),
      .ctrl_pc_jump_en_o(pc_jump_en), .ctrl_pc_jump_addr_o(pc_jump_addr),
      .ctrl_bus_err_o(bus_err), .ctrl_stall_cnt_o(stall_cnt)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle's inputs just after the rising edge, then waits to the falling edge to sample.
   task automatic applyStimulus(input logic r, input logic ld, input logic [4:0] rd,
                                input logic rs2u, input logic jmp, input logic [31:0] ja,
                                input logic req, input logic rdy);
      @(posedge clk);
      #1;
      rst          = r;
      idex_mem_en  = ld;
      idex_wb_en   = ld;
      idex_rd_addr = rd;
      id_rs2_use   = rs2u;
      ex_jump_en   = jmp;
      ex_jump_addr = ja;
      mem_req      = req;
      mem_ready    = rdy;
      @(negedge clk);
   endtask

   initial begin
      id_rs1_addr = 5'd3;
      id_rs2_addr = 5'd5;
      id_rs1_use  = 1'b1;
      rst = 1'b1; idex_mem_en = 0; idex_wb_en = 0; idex_rd_addr = 0; id_rs2_use = 0;
      ex_jump_en = 0; ex_jump_addr = 0; mem_req = 0; mem_ready = 0;

      // Reset: controls forced low even with active requests
      applyStimulus(1, 1, 5'd5, 1, 1, 32'h55, 1, 0);
      checkOutput("reset_ctrl", 64'(ctrl), 64'(NONE));
      checkOutput("reset_addr", 64'(pc_jump_addr), 64'd0);
      applyStimulus(0, 0, 5'd0, 0, 0, 32'h0, 0, 0);
      checkOutput("reset_bus_err", 64'(bus_err), 64'd0);
      checkOutput("reset_stall_cnt", 64'(stall_cnt), 64'd0);

      // No stall for rd=x0 or unused rs2
      applyStimulus(0, 1, 5'd0, 1, 0, 32'h0, 0, 0);
      checkOutput("lu_rd0", 64'(ctrl), 64'(NONE));
      id_rs2_addr = 5'd5;
      applyStimulus(0, 1, 5'd5, 0, 0, 32'h0, 0, 0);
      checkOutput("lu_rs2_unused", 64'(ctrl), 64'(NONE));
      applyStimulus(0, 0, 5'd0, 0, 0, 32'h0, 0, 0);
      checkOutput("lu_none_cnt", 64'(stall_cnt), 64'd0);

      // Genuine load-use: one bubble
      applyStimulus(0, 1, 5'd5, 1, 0, 32'h0, 0, 0);
      checkOutput("lu_bubble", 64'(ctrl), 64'(LU));
      applyStimulus(0, 0, 5'd0, 1, 0, 32'h0, 0, 0);
      checkOutput("lu_after", 64'(ctrl), 64'(NONE));
      checkOutput("lu_cnt", 64'(stall_cnt), 64'd1);

      // Jump outranks a simultaneous load-use
      applyStimulus(0, 1, 5'd5, 1, 1, 32'h0000_0100, 0, 0);
      checkOutput("jmp_ctrl", 64'(ctrl), 64'(JMP));
      checkOutput("jmp_addr", 64'(pc_jump_addr), 64'h100);

      // Memory wait, ready after 3 hold cycles
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 5'd0, 0, 0, 32'h0, 1, 0);
         checkOutput($sformatf("mw_hold%0d", i), 64'(ctrl), 64'(STALL));
      end
      applyStimulus(0, 0, 5'd0, 0, 0, 32'h0, 1, 1);
      checkOutput("mw_release", 64'(ctrl), 64'(NONE));
      applyStimulus(0, 0, 5'd0, 0, 0, 32'h0, 0, 0);
      checkOutput("mw_run", 64'(ctrl), 64'(NONE));
      checkOutput("mw_bus_err", 64'(bus_err), 64'd0);
      checkOutput("mw_cnt", 64'(stall_cnt), 64'd4);

      // Jump held off during the wait, taken on the ready cycle
      applyStimulus(0, 0, 5'd0, 0, 1, 32'h0000_0200, 1, 0);
      checkOutput("mwj_first", 64'(ctrl), 64'(STALL));
      applyStimulus(0, 0, 5'd0, 0, 1, 32'h0000_0200, 1, 0);
      checkOutput("mwj_wait", 64'(ctrl), 64'(STALL));
      applyStimulus(0, 0, 5'd0, 0, 1, 32'h0000_0200, 1, 1);
      checkOutput("mwj_ready", 64'(ctrl), 64'(JMP));
      checkOutput("mwj_addr", 64'(pc_jump_addr), 64'h200);

      // Timeout: 16 hold cycles then one abort cycle; ready in abort is ignored
      for (int i = 0; i < 16; i++) begin
         applyStimulus(0, 0, 5'd0, 0, 0, 32'h0, 1, 0);
         checkOutput($sformatf("to_hold%0d", i), 64'(ctrl), 64'(STALL));
      end
      applyStimulus(0, 0, 5'd0, 0, 0, 32'h0, 1, 1);
      checkOutput("to_abort", 64'(ctrl), 64'(ABRT));
      checkOutput("to_bus_err", 64'(bus_err), 64'd1);
      applyStimulus(0, 0, 5'd0, 0, 0, 32'h0, 0, 0);
      checkOutput("to_run", 64'(ctrl), 64'(NONE));
      checkOutput("to_sticky", 64'(bus_err), 64'd1);
      checkOutput("to_cnt", 64'(stall_cnt), 64'd22);

      // Reset in the middle of a wait
      applyStimulus(0, 0, 5'd0, 0, 0, 32'h0, 1, 0);
      applyStimulus(0, 0, 5'd0, 0, 0, 32'h0, 1, 0);
      checkOutput("rw_wait", 64'(ctrl), 64'(STALL));
      applyStimulus(1, 0, 5'd0, 0, 0, 32'h0, 1, 0);
      checkOutput("rw_in_reset", 64'(ctrl), 64'(NONE));
      applyStimulus(0, 0, 5'd0, 0, 0, 32'h0, 0, 0);
      checkOutput("rw_run", 64'(ctrl), 64'(NONE));
      checkOutput("rw_bus_err", 64'(bus_err), 64'd0);
      checkOutput("rw_cnt", 64'(stall_cnt), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
